// File: rtl/uart_clk_div_pkg.sv
// uart_clk_div_pkg: shared FSM states and constants for the UART clock divider
package uart_clk_div_pkg;
  typedef enum logic [1:0] {S_IDLE, S_HIGH, S_LOW} state_e;
  localparam int RATIO_WD_DEF = 8;
  localparam int MIN_DIV_RATIO = 2;
endpackage

// File: rtl/uart_clk_div_if.sv
// uart_clk_div_if: enable/ratio request and divided clock/tick/active ratio response
interface uart_clk_div_if import uart_clk_div_pkg::*; #(
  parameter int RATIO_WD = RATIO_WD_DEF
);
  logic I_CLK_EN;
  logic [RATIO_WD-1:0] I_DIV_RATIO;
  logic O_DIV_CLK;
  logic O_TICK;
  logic [RATIO_WD-1:0] O_ACTIVE_RATIO;
  modport master (
    output I_CLK_EN, I_DIV_RATIO,
    input O_DIV_CLK, O_TICK, O_ACTIVE_RATIO
  );
  modport slave (
    input I_CLK_EN, I_DIV_RATIO,
    output O_DIV_CLK, O_TICK, O_ACTIVE_RATIO
  );
endinterface

// File: rtl/uart_clk_div.sv
// uart_clk_div: boundary-updated integer clock divider with period tick; UART_CLK_DIV_BYPASS_EN passes CLK for ratio 0/1
module uart_clk_div import uart_clk_div_pkg::*; #(
  parameter int RATIO_WD = RATIO_WD_DEF
) (
  input logic CLK,
  input logic RST,
  uart_clk_div_if.slave bus
);
  state_e state_q, state_d;
  logic [RATIO_WD-1:0] cnt_q, cnt_d, ratio_q, ratio_d, half, low_len;
  logic div_clk_q, div_clk_d, tick_q, tick_d, new_ok, boundary;
  always_comb begin
    half = ratio_q >> 1;
    low_len = ratio_q - half;
    new_ok = bus.I_DIV_RATIO >= RATIO_WD'(MIN_DIV_RATIO);
    boundary = state_q == S_IDLE || (state_q == S_LOW && cnt_q == low_len);
    state_d = state_q;
    cnt_d = cnt_q;
    ratio_d = ratio_q;
    div_clk_d = 1'b0;
    tick_d = 1'b0;
    if (!bus.I_CLK_EN) begin
      state_d = S_IDLE;
      cnt_d = '0;
    end else if (boundary) begin
      ratio_d = bus.I_DIV_RATIO;
      state_d = new_ok ? S_HIGH : S_IDLE;
      cnt_d = new_ok ? RATIO_WD'(1) : '0;
      div_clk_d = new_ok;
      tick_d = new_ok || state_q == S_IDLE;
    end else if (state_q == S_HIGH && cnt_q == half) begin
      state_d = S_LOW;
      cnt_d = RATIO_WD'(1);
    end else begin
      cnt_d = cnt_q + RATIO_WD'(1);
      div_clk_d = state_q == S_HIGH;
    end
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_IDLE;
      cnt_q <= '0;
      ratio_q <= '0;
      div_clk_q <= 1'b0;
      tick_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      ratio_q <= ratio_d;
      div_clk_q <= div_clk_d;
      tick_q <= tick_d;
    end
  end
  assign bus.O_TICK = tick_q;
  assign bus.O_ACTIVE_RATIO = ratio_q;
`ifdef UART_CLK_DIV_BYPASS_EN
  logic byp_q;
  always_ff @(negedge CLK) byp_q <= !RST && bus.I_CLK_EN && tick_q && state_q == S_IDLE;
  assign bus.O_DIV_CLK = byp_q ? CLK : div_clk_q;
`else
  assign bus.O_DIV_CLK = div_clk_q;
`endif
endmodule
